// File: rtl/ise_dispatch_pkg.sv
// Shared definitions for the bit-manipulation ISE issue path.
// Function codes, legality and W-op predicates, result post-processing.
// Dispatcher FSM state encoding.
package ise_pkg;

    localparam logic [5:0] FN_ROR   = 6'd32;
    localparam logic [5:0] FN_ROL   = 6'd33;
    localparam logic [5:0] FN_RORI  = 6'd34;
    localparam logic [5:0] FN_ANDN  = 6'd35;
    localparam logic [5:0] FN_ORN   = 6'd36;
    localparam logic [5:0] FN_XNOR  = 6'd37;
    localparam logic [5:0] FN_PACK  = 6'd38;
    localparam logic [5:0] FN_PACKH = 6'd39;
    localparam logic [5:0] FN_RORW  = 6'd40;
    localparam logic [5:0] FN_ROLW  = 6'd41;
    localparam logic [5:0] FN_RORIW = 6'd42;
    localparam logic [5:0] FN_PACKW = 6'd43;

    localparam logic [5:0] FN_MIN = FN_ROR;
    localparam logic [5:0] FN_MAX = FN_PACKW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } disp_state_t;

    function automatic logic fn_legal(input logic [5:0] fn);
        return (fn >= FN_MIN) && (fn <= FN_MAX);
    endfunction

    // W ops produce a 32-bit result that is sign-extended to 64 bits.
    function automatic logic is_w_op(input logic [5:0] fn);
        return (fn >= FN_RORW) && (fn <= FN_PACKW);
    endfunction

    function automatic logic [63:0] post_process(input logic [5:0] fn, input logic [63:0] res);
        if (is_w_op(fn)) begin
            return {{32{res[31]}}, res[31:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/ise_dispatch_if.sv
// Request, unit and writeback signal bundle for the ISE dispatcher.
// master = dispatcher side, slave = core/unit/writeback environment.
// No storage; pure wiring.
interface ise_dispatch_if;

    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_fn;
    logic [63:0] req_rs1;
    logic [63:0] req_rs2;
    logic [4:0]  req_rd;

    logic [5:0]  ise_fn;
    logic [63:0] ise_in1;
    logic [63:0] ise_in2;
    logic        ise_val;
    logic        ise_oval;
    logic [63:0] ise_out;

    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_err;

    modport master (
        input  req_valid, req_fn, req_rs1, req_rs2, req_rd, ise_oval, ise_out, wb_ready,
        output req_ready, ise_fn, ise_in1, ise_in2, ise_val, wb_valid, wb_rd, wb_data, wb_err
    );

    modport slave (
        output req_valid, req_fn, req_rs1, req_rs2, req_rd, ise_oval, ise_out, wb_ready,
        input  req_ready, ise_fn, ise_in1, ise_in2, ise_val, wb_valid, wb_rd, wb_data, wb_err
    );

endinterface

// File: rtl/ise_dispatch_timer.sv
// Counts consecutive BUSY cycles without a unit answer.
// expired is combinational: high in the BUSY cycle that would be the TIMEOUT-th miss.
// No backpressure; clear has priority over count.
module ise_dispatch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Miss counter, restarted on every new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ise_dispatch.sv
// Issue controller for the ISE unit: holds operands until ise_oval, post-processes, writes back.
// Latency: 2 cycles accept->wb_valid with a same-cycle unit (+k for a k-cycle unit), 1 for illegal fn.
// Backpressure: wb_ready low holds RESP and blocks req_ready; ISE_DISPATCH_TIMEOUT_EN adds a BUSY abort timer.
module ise_dispatch
    import ise_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic          ise_clk,
    input  logic          ise_rst,
    ise_dispatch_if.master bus
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("ise_dispatch: TIMEOUT must be at least 1");
    end

    disp_state_t state_q, state_d;

    logic        req_ready;
    logic        accept;
    logic        ld_op;
    logic        ld_ill;
    logic        ld_res;
    logic        ld_tmo;
    logic        timeout_hit;

    logic [5:0]  fn_q;
    logic [63:0] in1_q;
    logic [63:0] in2_q;
    logic        ise_val_q;
    logic        wb_valid_q;
    logic [4:0]  rd_q;
    logic [63:0] data_q;
    logic        err_q;

`ifdef ISE_DISPATCH_TIMEOUT_EN
    ise_dispatch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (ise_clk),
        .rst     (ise_rst),
        .clr     (accept),
        .en      ((state_q == ST_BUSY) && !bus.ise_oval),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request acceptance and datapath load strobes.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        ld_op     = 1'b0;
        ld_ill    = 1'b0;
        ld_res    = 1'b0;
        ld_tmo    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_BUSY: begin
                // A result in the limit cycle beats the abort.
                if (bus.ise_oval) begin
                    ld_res  = 1'b1;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    ld_tmo  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                req_ready = bus.wb_ready;
                if (bus.wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A new request overrides the drain to IDLE, so RESP->BUSY has no bubble.
        if (req_ready && bus.req_valid) begin
            accept = 1'b1;
            if (fn_legal(bus.req_fn)) begin
                ld_op   = 1'b1;
                state_d = ST_BUSY;
            end else begin
                ld_ill  = 1'b1;
                state_d = ST_RESP;
            end
        end
    end

    // Registered unit-side and writeback-side outputs.
    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            fn_q       <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            ise_val_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            ise_val_q  <= (state_d == ST_BUSY);
            wb_valid_q <= (state_d == ST_RESP);
            if (accept) begin
                rd_q <= bus.req_rd;
            end
            if (ld_op) begin
                fn_q  <= bus.req_fn;
                in1_q <= bus.req_rs1;
                in2_q <= bus.req_rs2;
            end
            if (ld_ill || ld_tmo) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end else if (ld_res) begin
                data_q <= post_process(fn_q, bus.ise_out);
                err_q  <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.ise_fn    = fn_q;
    assign bus.ise_in1   = in1_q;
    assign bus.ise_in2   = in2_q;
    assign bus.ise_val   = ise_val_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = rd_q;
    assign bus.wb_data   = data_q;
    assign bus.wb_err    = err_q;

endmodule

// File: doc/ise_dispatch.md
# ise_dispatch

Issue-side controller for the bit-manipulation ISE functional unit. It accepts one decoded ISE request at a time from the core execute stage, holds the operands on the unit's `ise_fn`/`ise_in1`/`ise_in2`/`ise_val` inputs until the unit answers on `ise_oval`/`ise_out`, post-processes the result, and presents it on a backpressured writeback port. It sits between the core pipeline and the ISE unit. It supports both combinational (same-cycle `ise_oval`) and multi-cycle units.

## Interface

Parameters:
- `TIMEOUT`, 16: number of consecutive BUSY cycles without `ise_oval` before the request is aborted. Minimum 1.

Ports:
- `ise_clk`  in  1  clock, rising edge.
- `ise_rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  dispatcher can accept a request.
- `req_fn`  in  6  ISE function code.
- `req_rs1`  in  64  operand 1.
- `req_rs2`  in  64  operand 2 or immediate.
- `req_rd`  in  5  destination register tag.
- `ise_fn`  out  6  function code to the unit.
- `ise_in1`  out  64  operand 1 to the unit.
- `ise_in2`  out  64  operand 2 to the unit.
- `ise_val`  out  1  request valid to the unit.
- `ise_oval`  in  1  unit result valid.
- `ise_out`  in  64  unit result.
- `wb_valid`  out  1  writeback valid.
- `wb_ready`  in  1  writeback accepted.
- `wb_rd`  out  5  destination tag.
- `wb_data`  out  64  result.
- `wb_err`  out  1  illegal function or timeout.

## Operation

- States: IDLE, BUSY, RESP. Reset state is IDLE.
- Accept: a request is taken when `req_valid & req_ready`. `req_ready = (state==IDLE) | (state==RESP & wb_ready)`.
- On accept with legal `req_fn` (32..43):
  - Register fn, rs1, rs2 and rd.
  - Clear the timer.
  - Go to BUSY.
- On accept with illegal `req_fn`:
  - Go to RESP with `wb_err=1`, `wb_data=0`, and `wb_rd` set to the captured tag.
  - `ise_val` is never raised.
- BUSY:
  - `ise_val=1`. `ise_fn`, `ise_in1` and `ise_in2` hold the registered values and are stable.
  - When `ise_oval=1`, capture the processed `ise_out`, set `wb_err=0`, and go to RESP.
- Result processing: for W ops (fn 40 RORW, 41 ROLW, 42 RORIW, 43 PACKW), `wb_data = {{32{ise_out[31]}}, ise_out[31:0]}`. All other fns pass through unchanged.
- RESP:
  - `wb_valid=1`. `wb_rd`, `wb_data` and `wb_err` stay stable until `wb_ready`.
  - On `wb_ready` with a simultaneous accept, load the new request (BUSY or RESP by legality) with no bubble.
  - On `wb_ready` without an accept, go to IDLE.
- Outside BUSY, `ise_oval` and `ise_out` are ignored.
- Timeout (macro enabled):
  - The timer counts BUSY cycles with `ise_oval=0`.
  - When the count reaches `TIMEOUT` with no `ise_oval`, go to RESP with `wb_err=1` and `wb_data=0`.
  - If `ise_oval` arrives in the same cycle the limit is reached, `ise_oval` wins and the result is valid.
- Reset mid-operation aborts immediately: no writeback is produced and the in-flight request is dropped.

## Timing

- Reset values:
  - `ise_val=0`, `ise_fn=0`, `ise_in1=0`, `ise_in2=0`.
  - `wb_valid=0`, `wb_rd=0`, `wb_data=0`, `wb_err=0`.
  - `req_ready=1` (IDLE).
- Accept at edge N:
  - `ise_val` is high during cycle N+1.
  - With a same-cycle `ise_oval`, `wb_valid` is high in cycle N+2. Minimum latency is 2 cycles.
  - A unit that answers k cycles after `ise_val` rises gives latency 2+k.
- An illegal fn gives `wb_valid` in cycle N+1.
- Timeout: `ise_val` stays high for exactly `TIMEOUT` cycles, then `wb_valid` rises in the following cycle.
- Sustained throughput with a combinational unit and `wb_ready=1`: one result every 2 cycles.
- All outputs are registered except `req_ready`, which is combinational from state and `wb_ready`.

## Configuration

- `ISE_DISPATCH_TIMEOUT_EN` defined: the timer and abort path are present, and `wb_err` can signal a timeout.
- `ISE_DISPATCH_TIMEOUT_EN` undefined:
  - The timer is removed and BUSY waits indefinitely for `ise_oval`.
  - `wb_err` is asserted only for illegal fn.
  - `TIMEOUT` is unused.

## Structure

- Shared package `ise_pkg`:
  - FN codes FN_ROR=32 through FN_PACKW=43.
  - FN_MIN=32, FN_MAX=43.
  - A W-op predicate function.
  - A dispatcher state enum.
- Sub-module `ise_dispatch_timer`, instantiated only under the macro:
  - Width is $clog2(TIMEOUT+1).
  - Inputs: clear and count enable.
  - Output: `expired`.

## Test plan

- ROR: fn=32, rs1=0x1, rs2=1, same-cycle unit returns 0x8000_0000_0000_0000 -> `wb_valid` at N+2, `wb_data`=0x8000_0000_0000_0000, `wb_err`=0, `wb_rd` matches the request.
- RORW sign-extension: fn=40, unit returns 0x0000_0000_8000_0000 -> `wb_data`=0xFFFF_FFFF_8000_0000. PACKW returning 0x0000_0000_1234_5678 -> unchanged.
- Illegal fn=5 -> `wb_valid` at N+1, `wb_err`=1, `wb_data`=0, `ise_val` never asserted.
- Timeout, TIMEOUT=16, `ise_oval` held 0:
  - Macro enabled: `ise_val` high for 16 cycles, then `wb_err`=1 and `wb_data`=0.
  - Macro disabled: still BUSY after 100 cycles.
  - `ise_oval` arriving on cycle 16 gives a valid result.
- Backpressure: `wb_ready`=0 for 3 cycles -> `wb_*` stable. Then `wb_ready=1` with `req_valid=1` in the same cycle -> the new request is accepted and `ise_val` rises the next cycle.
- Reset asserted mid-BUSY -> `ise_val` and `wb_valid` drop asynchronously, no writeback after release, and `req_ready=1` after release.
